// File: rtl/bcd_score_counter_pkg.sv
// Shared types and constants for the BCD score counter: FSM states, BCD limits
// and digit positions within the packed score register.
package bcd_score_counter_pkg;

  typedef enum logic [2:0] {S_IDLE, S_D0, S_D1, S_D2, S_D3, S_DONE} state_e;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam int         DIG_ONES  = 0;
  localparam int         DIG_TENS  = 1;
  localparam int         DIG_HUNS  = 2;
  localparam int         DIG_THOUS = 3;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_score_counter_if.sv
// Score interface: game-side controls in, 4-digit BCD score and status out.
interface bcd_score_counter_if;
  logic       clear;
  logic       pause;
  logic       hit;
  logic [3:0] points;
  logic [3:0] thous;
  logic [3:0] huns;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       score_updated;
  logic       saturated;

  modport master (input  clear, pause, hit, points,
                  output thous, huns, tens, ones, score_updated, saturated);
  modport slave  (output clear, pause, hit, points,
                  input  thous, huns, tens, ones, score_updated, saturated);
endinterface

// File: rtl/bcd_score_counter_digit_add.sv
// Single-digit BCD adder: a + b + cin folded back into 0-9 with carry out.
module bcd_digit_add (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
    if (raw > 5'd9) begin
      sum_o  = 4'(raw - 5'd10);
      cout_o = 1'b1;
    end else begin
      sum_o  = raw[3:0];
      cout_o = 1'b0;
    end
  end
endmodule

// File: rtl/bcd_score_counter.sv
// 4-digit BCD score counter: hit edges are queued and added serially one digit
// per cycle through a shared digit adder; the score pins at 9999 on overflow.
module bcd_score_counter
  import bcd_score_counter_pkg::*;
#(
  parameter int PEND_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  bcd_score_counter_if.master bus
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_q;
  logic [3:0][3:0]   dig_q;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [3:0]        addend_q;
  logic              hit_q, carry_q, sat_q, upd_q;
  logic              rise, accept, start;
  logic [1:0]        idx;
  logic [3:0]        add_b, add_sum;
  logic              add_cout;

  assign rise   = bus.hit & ~hit_q;
  assign accept = rise & ~bus.pause & ~sat_q & (pend_q != PEND_MAX);
  assign start  = (state_q == S_IDLE) & (pend_q != '0) & ~bus.pause & ~sat_q;

  always_comb begin
    pend_d = pend_q;
    if (state_q == S_IDLE && sat_q)  pend_d = '0;
    else if (accept && !start)       pend_d = pend_q + 1'b1;
    else if (!accept && start)       pend_d = pend_q - 1'b1;
  end

  // The adder is steered onto whichever digit the current state owns; only
  // D0 brings in the addend, later digits just absorb the ripple carry.
  always_comb begin
    case (state_q)
      S_D1:    idx = 2'(DIG_TENS);
      S_D2:    idx = 2'(DIG_HUNS);
      S_D3:    idx = 2'(DIG_THOUS);
      default: idx = 2'(DIG_ONES);
    endcase
    add_b = (state_q == S_D0) ? addend_q : 4'd0;
  end

  bcd_digit_add u_add (
    .a_i   (dig_q[idx]),
    .b_i   (add_b),
    .cin_i (carry_q),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dig_q    <= '0;
      pend_q   <= '0;
      addend_q <= '0;
      hit_q    <= 1'b0;
      carry_q  <= 1'b0;
      sat_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      hit_q <= bus.hit;
      if (bus.clear) begin
        state_q <= S_IDLE;
        dig_q   <= '0;
        pend_q  <= '0;
        carry_q <= 1'b0;
        sat_q   <= 1'b0;
        upd_q   <= 1'b0;
      end else begin
        pend_q <= pend_d;
        upd_q  <= 1'b0;
        case (state_q)
          S_IDLE: if (start) begin
            addend_q <= bcd_clamp(bus.points);
            carry_q  <= 1'b0;
            state_q  <= S_D0;
          end
          S_D0, S_D1, S_D2: begin
            dig_q[idx] <= add_sum;
            carry_q    <= add_cout;
            state_q    <= (state_q == S_D0) ? S_D1 :
                          (state_q == S_D1) ? S_D2 : S_D3;
          end
          S_D3: begin
            // Carry out of thousands means overflow: pin the whole score.
            if (add_cout) begin
              dig_q <= {4{BCD_MAX}};
              sat_q <= 1'b1;
            end else begin
              dig_q[idx] <= add_sum;
            end
            upd_q   <= 1'b1;
            state_q <= S_DONE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ones          = dig_q[DIG_ONES];
  assign bus.tens          = dig_q[DIG_TENS];
  assign bus.huns          = dig_q[DIG_HUNS];
  assign bus.thous         = dig_q[DIG_THOUS];
  assign bus.score_updated = upd_q;
  assign bus.saturated     = sat_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench for bcd_score_counter: integer-score reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_bcd_score_counter;
  localparam int PEND_MAX = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_score_counter_if bus();
  bcd_score_counter #(.PEND_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, n_pulse = 0;

  // reference model: score as a plain integer, m_ph = cycles into an add
  // (0 idle, 1..4 ripple phases, 5 done), m_sum = old score + points
  int m_score, m_sum, m_pend, m_ph;
  bit m_sat, m_upd, m_prev;

  function automatic int dig(input int v, input int i);
    int d = 1;
    for (int k = 0; k < i; k++) d *= 10;
    return (v / d) % 10;
  endfunction

  function automatic int exp_dig(input int i);
    if (m_ph >= 2 && m_ph <= 4 && i < m_ph - 1) return dig(m_sum % 10000, i);
    return dig(m_score, i);
  endfunction

  function automatic int dut_score();
    return int'(bus.thous) * 1000 + int'(bus.huns) * 100 + int'(bus.tens) * 10 + int'(bus.ones);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_sum = 0; m_pend = 0; m_ph = 0;
    m_sat = 0; m_upd = 0; m_prev = 0;
  endtask

  task automatic model_step();
    bit rise, acc, start;
    int p;
    rise = bus.hit && !m_prev;
    m_prev = bus.hit;
    if (bus.clear) begin
      m_score = 0; m_sum = 0; m_pend = 0; m_ph = 0; m_sat = 0; m_upd = 0;
      return;
    end
    acc   = rise && !bus.pause && !m_sat && (m_pend < PEND_MAX);
    start = 0;
    m_upd = 0;
    case (m_ph)
      0: begin
        if (m_sat) m_pend = 0;
        else if (m_pend > 0 && !bus.pause) begin
          start = 1;
          p = (bus.points > 9) ? 9 : int'(bus.points);
          m_sum = m_score + p;
          m_ph = 1;
        end
      end
      1, 2, 3: m_ph++;
      4: begin
        m_ph = 5;
        m_upd = 1;
        if (m_sum > 9999) begin m_score = 9999; m_sat = 1; end
        else m_score = m_sum;
      end
      default: m_ph = 0;
    endcase
    m_pend = m_pend + (acc ? 1 : 0) - (start ? 1 : 0);
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst) model_step();
  end

  initial forever begin
    @(negedge clk);
    check("ones",  bus.ones,  exp_dig(0));
    check("tens",  bus.tens,  exp_dig(1));
    check("huns",  bus.huns,  exp_dig(2));
    check("thous", bus.thous, exp_dig(3));
    check("score_updated", bus.score_updated, m_upd);
    check("saturated", bus.saturated, m_sat);
    if (bus.score_updated) n_pulse++;
  end

  task automatic add_hit(input int p);
    @(negedge clk); bus.points = 4'(p); bus.hit = 1'b1;
    @(negedge clk); bus.hit = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk); bus.clear = 1'b1;
    @(negedge clk); bus.clear = 1'b0;
  endtask

  int p0;

  initial begin
    bus.clear = 0; bus.pause = 0; bus.hit = 0; bus.points = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_score", dut_score(), 0);
    check("reset_sat", bus.saturated, 0);

    // single hit of 5: ones after k+2, pulse only between k+5 and k+6
    @(negedge clk); bus.points = 4'd5; bus.hit = 1'b1;
    @(negedge clk); bus.hit = 1'b0;
    @(negedge clk); check("ones_at_k1", bus.ones, 0);
    @(negedge clk); check("ones_at_k2", bus.ones, 5);
    @(negedge clk); check("pulse_k3", bus.score_updated, 0);
    repeat (2) @(negedge clk); check("pulse_k5", bus.score_updated, 1);
    @(negedge clk); check("pulse_k6", bus.score_updated, 0);
    check("score_5", dut_score(), 5);

    // 0998 + 7 ripples to 1005
    do_clear();
    for (int i = 0; i < 110; i++) add_hit(9);
    add_hit(8);
    check("score_998", dut_score(), 998);
    p0 = n_pulse;
    add_hit(7);
    check("score_1005", dut_score(), 1005);
    check("pulses_1005", n_pulse - p0, 1);
    check("sat_1005", bus.saturated, 0);

    // async reset during D2 of an add on 0042
    do_clear();
    for (int i = 0; i < 4; i++) add_hit(9);
    add_hit(6);
    check("score_42", dut_score(), 42);
    @(negedge clk); bus.points = 4'd1; bus.hit = 1'b1;
    @(negedge clk); bus.hit = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_score", dut_score(), 0);
    check("rst_async_upd", bus.score_updated, 0);
    check("rst_async_sat", bus.saturated, 0);
    p0 = n_pulse;
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_pulse", n_pulse - p0, 0);
    check("rst_score_after", dut_score(), 0);

    // four rises two cycles apart, all queued
    p0 = n_pulse;
    bus.points = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.hit = 1'b1;
      @(negedge clk); bus.hit = 1'b0;
    end
    repeat (30) @(negedge clk);
    check("score_12", dut_score(), 12);
    check("pulses_4", n_pulse - p0, 4);

    // pause drops rises
    p0 = n_pulse;
    bus.pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus.hit = 1'b1;
      @(negedge clk); bus.hit = 1'b0;
    end
    @(negedge clk); bus.pause = 1'b0;
    repeat (10) @(negedge clk);
    check("pause_score", dut_score(), 12);
    check("pause_pulses", n_pulse - p0, 0);

    // clear with three hits still pending
    bus.points = 4'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.hit = 1'b1;
      @(negedge clk); bus.hit = 1'b0;
    end
    do_clear();
    p0 = n_pulse;
    repeat (20) @(negedge clk);
    check("clear_score", dut_score(), 0);
    check("clear_pulses", n_pulse - p0, 0);

    // hit held high scores exactly once
    p0 = n_pulse;
    @(negedge clk); bus.points = 4'd4; bus.hit = 1'b1;
    repeat (100) @(negedge clk);
    bus.hit = 1'b0;
    repeat (10) @(negedge clk);
    check("held_score", dut_score(), 4);
    check("held_pulses", n_pulse - p0, 1);

    // exactly 9999 without overflow, then 0, then a nonzero hit saturates
    do_clear();
    for (int i = 0; i < 1111; i++) add_hit(9);
    check("score_9999", dut_score(), 9999);
    check("sat_9999_exact", bus.saturated, 0);
    p0 = n_pulse;
    add_hit(0);
    check("zero_hit_pulse", n_pulse - p0, 1);
    check("zero_hit_sat", bus.saturated, 0);
    add_hit(1);
    check("overflow_sat", bus.saturated, 1);
    check("overflow_score", dut_score(), 9999);

    // 9995 + 9 saturates; later hits give no pulse
    do_clear();
    check("clear_unsat", bus.saturated, 0);
    for (int i = 0; i < 1110; i++) add_hit(9);
    add_hit(5);
    check("score_9995", dut_score(), 9995);
    p0 = n_pulse;
    add_hit(9);
    check("sat_9995", bus.saturated, 1);
    check("sat_score", dut_score(), 9999);
    check("sat_pulse", n_pulse - p0, 1);
    p0 = n_pulse;
    add_hit(3); add_hit(3);
    check("sat_no_pulse", n_pulse - p0, 0);

    // random traffic with occasional pause and clear
    do_clear();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) bus.hit = ~bus.hit;
      bus.pause  = ($urandom_range(0, 9) == 0);
      bus.clear  = ($urandom_range(0, 149) == 0);
      bus.points = 4'($urandom_range(0, 15));
    end
    @(negedge clk); bus.hit = 0; bus.pause = 0; bus.clear = 0;
    repeat (60) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_score_counter.md
Name: bcd_score_counter

Overview:
- Producer end of the 4-digit BCD score interface. It drives thous/huns/tens/ones into the seven-segment scan mux and the pixel_generation score inputs.
- Converts the game's level "hit" signal into scored points using a serial BCD adder, one digit per cycle.
- Queues hits that arrive while an add is in flight and saturates the score at 9999.
- Lives in the 100 MHz clk domain, next to pixel_generation.

Parameters:
PEND_W, 3, width of the pending-hit counter; queue depth is PEND_MAX = 2^PEND_W-1 (7).

Ports:
clk  input  1  100 MHz master clock
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous score clear, highest synchronous priority
pause  input  1  game paused; new hits ignored and queued adds not started
hit  input  1  collision level from pixel logic; each 0->1 edge scores once
points  input  4  BCD points per hit (0-9); values >9 clamp to 9; sampled when an add starts
thous  output  4  BCD thousands digit
huns  output  4  BCD hundreds digit
tens  output  4  BCD tens digit
ones  output  4  BCD ones digit
score_updated  output  1  one-cycle pulse when a new score is final
saturated  output  1  sticky flag; score overflowed and is pinned at 9999

Behaviour:
- Reset (async, rst=1): all digits 0, pend=0, hit_q=0, saturated=0, score_updated=0, state IDLE.
- Edge detect:
  - hit_q <= hit every cycle, including during clear.
  - rise = hit & ~hit_q.
  - A rise is accepted only if pause=0 and saturated=0.
- Pending counter pend (PEND_W bits):
  - Increments on an accepted rise.
  - Decrements when the FSM leaves IDLE.
  - If both happen in the same cycle, pend is unchanged.
  - At PEND_MAX, further rises are dropped.
- FSM states: IDLE, D0, D1, D2, D3, DONE.
  - IDLE: if pend>0, pause=0 and saturated=0, then: addend <= clamp(points); carry <= 0; go to D0.
  - IDLE: if saturated=1, pend is forced to 0.
  - D0: {carry,ones} <= ones+addend (minus 10 with carry=1 if the sum is >9); go to D1.
  - D1: tens += carry with the same rule; go to D2.
  - D2: huns += carry; go to D3.
  - D3: thous += carry. On carry-out, all four digits <= 9 and saturated <= 1. Go to DONE; score_updated <= 1 on this edge.
  - DONE: score_updated <= 0; go to IDLE.
- Latency:
  - Rise sampled at edge k → pend=1 after k.
  - Add starts at k+1; ones valid after k+2; thous valid after k+5.
  - score_updated is high for exactly the cycle between edges k+5 and k+6.
  - Throughput is one hit per 6 cycles.
- Intermediate digit values during D0-D3 are visible on the outputs. Consumers latch only on score_updated or tolerate the short ripple.
- pause does not abort an add in flight; it completes and pulses normally.
- points=0 hit: digits unchanged, score_updated still pulses.
- Exactly 9999 without a carry-out leaves saturated=0. The next nonzero hit sets it.
- clear=1 (synchronous, overrides all other updates):
  - Digits 0, pend 0, saturated 0, score_updated 0, state IDLE.
  - Any add in flight is discarded.
  - A rise in the same cycle as clear is not queued.
- Digits never hold a non-BCD value. Every arithmetic path yields 0-9.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, D0-D3, DONE).
  - BCD_MAX = 4'd9.
  - Digit index constants.
- One sub-module: bcd_digit_add. It is combinational: a[3:0], b[3:0], cin → sum[3:0], cout. It is used once per cycle, muxed onto the active digit.

Test Plan:
- rst pulse mid-add (during D2) with score 0042 → all outputs 0 immediately; no score_updated follows.
- Score 0000, points=5, single hit rise → ones=5 after edge k+2; score_updated high in cycle k+5..k+6 only; final 0005.
- Score 0998, points=7, hit → carry ripples through tens and huns; final 1005 with one pulse; saturated=0.
- Four rises 2 cycles apart, points=3, score 0000 → all four queued; four pulses 6 cycles apart; final 0012.
- Score 9995, points=9, hit → digits 9999, saturated=1; further hits give no pulse, pend stays 0.
- Dropped hits and clear:
  - pause=1 with 2 rises → no change.
  - clear while pend=3 → 0000, pend=0, no pulses.
  - hit held high for 100 cycles → exactly one score.
